// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS ALU control unit: ALUOp classes,
// funct codes, ALU selector values, mul-div op and FSM state types.
package alu_ctrl_pkg;

  // ALUOp classes driven by the main control FSM
  localparam logic [2:0] AluOpAdd   = 3'b000;
  localparam logic [2:0] AluOpSub   = 3'b001;
  localparam logic [2:0] AluOpFunct = 3'b010;
  localparam logic [2:0] AluOpXor   = 3'b011;
  localparam logic [2:0] AluOpAnd   = 3'b100;
  localparam logic [2:0] AluOpSlt   = 3'b101;

  // R-type funct field values
  localparam logic [5:0] FnAdd   = 6'h20;
  localparam logic [5:0] FnAddu  = 6'h21;
  localparam logic [5:0] FnSub   = 6'h22;
  localparam logic [5:0] FnSubu  = 6'h23;
  localparam logic [5:0] FnAnd   = 6'h24;
  localparam logic [5:0] FnXor   = 6'h26;
  localparam logic [5:0] FnSlt   = 6'h2a;
  localparam logic [5:0] FnMult  = 6'h18;
  localparam logic [5:0] FnMultu = 6'h19;
  localparam logic [5:0] FnDiv   = 6'h1a;
  localparam logic [5:0] FnDivu  = 6'h1b;
  localparam logic [5:0] FnBreak = 6'h0d;

  // ALU selector (Saida) values
  localparam logic [2:0] SelLoadA = 3'b000;
  localparam logic [2:0] SelAdd   = 3'b001;
  localparam logic [2:0] SelSub   = 3'b010;
  localparam logic [2:0] SelAnd   = 3'b011;
  localparam logic [2:0] SelXor   = 3'b110;
  localparam logic [2:0] SelSlt   = 3'b111;

  typedef enum logic [1:0] {
    MdMult  = 2'b00,
    MdMultu = 2'b01,
    MdDiv   = 2'b10,
    MdDivu  = 2'b11
  } md_op_e;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StMulDiv = 1'b1
  } state_e;

  // Counter width able to hold (max cycles - 1); at least one bit
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return ($clog2(m) > 0) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational ALUOp/Funct decoder: ALU selector, overflow enable,
// mul-div detection and op, and BREAK detection.
module alu_funct_decode
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned FUNCT_W = 6,
  parameter int unsigned OP_W    = 3
) (
  input  logic [OP_W-1:0]    alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [SEL_W-1:0]   saida,
  output logic               ovf_en,
  output logic               is_muldiv,
  output md_op_e             md_op,
  output logic               is_break
);

  // Compare on zero-extended copies so any field width works against the constants
  logic [31:0] op_x;
  logic [31:0] fn_x;
  logic [2:0]  sel;

  assign op_x  = 32'(alu_op);
  assign fn_x  = 32'(funct);
  assign saida = SEL_W'(sel);

  // Decode operation class and, for R-type, the funct field
  always_comb begin
    sel       = SelLoadA;
    ovf_en    = 1'b0;
    is_muldiv = 1'b0;
    md_op     = MdMult;
    is_break  = 1'b0;
    case (op_x)
      32'(AluOpAdd): sel = SelAdd;
      32'(AluOpSub): sel = SelSub;
      32'(AluOpXor): sel = SelXor;
      32'(AluOpAnd): sel = SelAnd;
      32'(AluOpSlt): sel = SelSlt;
      32'(AluOpFunct): begin
        case (fn_x)
          32'(FnAdd): begin
            sel    = SelAdd;
            ovf_en = 1'b1;
          end
          32'(FnAddu): sel = SelAdd;
          32'(FnSub): begin
            sel    = SelSub;
            ovf_en = 1'b1;
          end
          32'(FnSubu): sel = SelSub;
          32'(FnAnd):  sel = SelAnd;
          32'(FnXor):  sel = SelXor;
          32'(FnSlt):  sel = SelSlt;
          32'(FnMult): begin
            is_muldiv = 1'b1;
            md_op     = MdMult;
          end
          32'(FnMultu): begin
            is_muldiv = 1'b1;
            md_op     = MdMultu;
          end
          32'(FnDiv): begin
            is_muldiv = 1'b1;
            md_op     = MdDiv;
          end
          32'(FnDivu): begin
            is_muldiv = 1'b1;
            md_op     = MdDivu;
          end
          32'(FnBreak): is_break = 1'b1;
          default: sel = SelLoadA;
        endcase
      end
      default: sel = SelLoadA;
    endcase
  end

endmodule

// File: rtl/alu_control_seq.sv
// Registered ALU control unit: single-cycle decode with Done pulse, multi-cycle
// MULT/DIV sequencing with Busy/Done handshake, and a sticky Break flag.
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned SEL_W       = 3,
  parameter int unsigned FUNCT_W     = 6,
  parameter int unsigned OP_W        = 3,
  parameter int unsigned MULT_CYCLES = 32,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Start,
  input  logic [FUNCT_W-1:0] Funct,
  input  logic [OP_W-1:0]    ALUOp,
  input  logic               BreakClr,
  output logic               Ready,
  output logic [SEL_W-1:0]   Saida,
  output logic               OvfEn,
  output logic               MdStart,
  output logic [1:0]         MdOp,
  output logic               Busy,
  output logic               Done,
  output logic               Break
);

  localparam int unsigned CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   saida_q, saida_d;
  logic               ovf_q, ovf_d;
  logic               mdstart_q, mdstart_d;
  md_op_e             mdop_q, mdop_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               break_q, break_d;

  logic [SEL_W-1:0]   dec_saida;
  logic               dec_ovf;
  logic               dec_is_muldiv;
  md_op_e             dec_md_op;
  logic               dec_is_break;

  logic               accept;
  logic               cnt_last;

  alu_funct_decode #(
    .SEL_W   (SEL_W),
    .FUNCT_W (FUNCT_W),
    .OP_W    (OP_W)
  ) u_decode (
    .alu_op    (ALUOp),
    .funct     (Funct),
    .saida     (dec_saida),
    .ovf_en    (dec_ovf),
    .is_muldiv (dec_is_muldiv),
    .md_op     (dec_md_op),
    .is_break  (dec_is_break)
  );

  assign accept   = Start && (state_q == StIdle);
  // Counter reaching zero on this edge ends the sequence: N cycles Start-to-Done
  assign cnt_last = (cnt_q == CNT_W'(1));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept && dec_is_muldiv) state_d = StMulDiv;
      StMulDiv: if (cnt_last) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Next values of registered outputs and the cycle counter
  always_comb begin
    saida_d   = saida_q;
    ovf_d     = ovf_q;
    mdstart_d = 1'b0;
    mdop_d    = mdop_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    // Clear loses to a same-cycle set, applied below
    break_d   = break_q && !BreakClr;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (dec_is_muldiv) begin
            mdop_d    = dec_md_op;
            mdstart_d = 1'b1;
            busy_d    = 1'b1;
            saida_d   = '0;
            ovf_d     = 1'b0;
            cnt_d     = dec_md_op[1] ? DivLoad : MultLoad;
          end else begin
            saida_d = dec_saida;
            ovf_d   = dec_ovf;
            done_d  = 1'b1;
            if (dec_is_break) break_d = 1'b1;
          end
        end
      end
      StMulDiv: begin
        if (cnt_last) begin
          done_d = 1'b1;
          busy_d = 1'b0;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Output and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      saida_q   <= '0;
      ovf_q     <= 1'b0;
      mdstart_q <= 1'b0;
      mdop_q    <= MdMult;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      break_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      saida_q   <= saida_d;
      ovf_q     <= ovf_d;
      mdstart_q <= mdstart_d;
      mdop_q    <= mdop_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      break_q   <= break_d;
    end
  end

  assign Ready   = (state_q == StIdle);
  assign Saida   = saida_q;
  assign OvfEn   = ovf_q;
  assign MdStart = mdstart_q;
  assign MdOp    = mdop_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Break   = break_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed bench for alu_control_seq: table of single-cycle decodes applied
// back-to-back, plus hand-written mul-div, break and reset sequences.
module tb_alu_control_seq;

  logic       clk;
  logic       reset;
  logic       Start;
  logic [5:0] Funct;
  logic [2:0] ALUOp;
  logic       BreakClr;
  logic       Ready;
  logic [2:0] Saida;
  logic       OvfEn;
  logic       MdStart;
  logic [1:0] MdOp;
  logic       Busy;
  logic       Done;
  logic       Break;

  int tests;
  int fails;

  alu_control_seq #(
    .SEL_W       (3),
    .FUNCT_W     (6),
    .OP_W        (3),
    .MULT_CYCLES (4),
    .DIV_CYCLES  (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .Start    (Start),
    .Funct    (Funct),
    .ALUOp    (ALUOp),
    .BreakClr (BreakClr),
    .Ready    (Ready),
    .Saida    (Saida),
    .OvfEn    (OvfEn),
    .MdStart  (MdStart),
    .MdOp     (MdOp),
    .Busy     (Busy),
    .Done     (Done),
    .Break    (Break)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [5:0] fn;
    logic [2:0] sel;
    logic       ovf;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_saida"}, 32'(Saida), 32'd0);
    check({tag, "_ovf"}, 32'(OvfEn), 32'd0);
    check({tag, "_mdstart"}, 32'(MdStart), 32'd0);
    check({tag, "_mdop"}, 32'(MdOp), 32'd0);
    check({tag, "_busy"}, 32'(Busy), 32'd0);
    check({tag, "_done"}, 32'(Done), 32'd0);
    check({tag, "_break"}, 32'(Break), 32'd0);
    check({tag, "_ready"}, 32'(Ready), 32'd1);
  endtask

  // Launch a mul-div op and measure Busy length and Done latency
  task automatic run_md(input string tag, input logic [5:0] fn, input logic [1:0] exp_op,
                        input int n, input bit start_while_busy);
    int done_cyc;
    int busy_cnt;
    Start = 1'b1;
    ALUOp = 3'b010;
    Funct = fn;
    tick();
    check({tag, "_mdstart"}, 32'(MdStart), 32'd1);
    check({tag, "_mdop"}, 32'(MdOp), 32'(exp_op));
    check({tag, "_busy0"}, 32'(Busy), 32'd1);
    check({tag, "_ready0"}, 32'(Ready), 32'd0);
    check({tag, "_done0"}, 32'(Done), 32'd0);
    Start    = start_while_busy;
    ALUOp    = 3'b000;
    Funct    = 6'h20;
    done_cyc = 0;
    busy_cnt = (Busy === 1'b1) ? 1 : 0;
    for (int c = 2; c <= 40; c++) begin
      tick();
      if (c == 2) check({tag, "_mdstart_pulse"}, 32'(MdStart), 32'd0);
      if (Done === 1'b1) begin
        done_cyc = c;
        break;
      end
      if (Busy === 1'b1) busy_cnt++;
    end
    check({tag, "_latency"}, 32'(done_cyc), 32'(n));
    check({tag, "_busy_len"}, 32'(busy_cnt), 32'(n - 1));
    check({tag, "_busy_end"}, 32'(Busy), 32'd0);
    check({tag, "_saida"}, 32'(Saida), 32'd0);
    check({tag, "_ready_end"}, 32'(Ready), 32'd1);
    Start = 1'b0;
    tick();
    check({tag, "_done_pulse"}, 32'(Done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    tests = 0;
    fails = 0;

    vecs[0]  = '{3'b010, 6'h20, 3'b001, 1'b1};
    vecs[1]  = '{3'b011, 6'h00, 3'b110, 1'b0};
    vecs[2]  = '{3'b101, 6'h00, 3'b111, 1'b0};
    vecs[3]  = '{3'b010, 6'h21, 3'b001, 1'b0};
    vecs[4]  = '{3'b000, 6'h22, 3'b001, 1'b0};
    vecs[5]  = '{3'b001, 6'h20, 3'b010, 1'b0};
    vecs[6]  = '{3'b100, 6'h00, 3'b011, 1'b0};
    vecs[7]  = '{3'b010, 6'h22, 3'b010, 1'b1};
    vecs[8]  = '{3'b010, 6'h23, 3'b010, 1'b0};
    vecs[9]  = '{3'b010, 6'h24, 3'b011, 1'b0};
    vecs[10] = '{3'b010, 6'h26, 3'b110, 1'b0};
    vecs[11] = '{3'b010, 6'h2a, 3'b111, 1'b0};
    vecs[12] = '{3'b010, 6'h3f, 3'b000, 1'b0};
    vecs[13] = '{3'b111, 6'h20, 3'b000, 1'b0};
    vecs[14] = '{3'b110, 6'h22, 3'b000, 1'b0};
    vecs[15] = '{3'b010, 6'h00, 3'b000, 1'b0};
    vecs[16] = '{3'b010, 6'h25, 3'b000, 1'b0};
    vecs[17] = '{3'b001, 6'h22, 3'b010, 1'b0};

    // Reset held with an active mul-div request: everything stays cleared
    reset    = 1'b0;
    Start    = 1'b1;
    ALUOp    = 3'b010;
    Funct    = 6'h18;
    BreakClr = 1'b0;
    tick();
    tick();
    tick();
    check_idle("rst_hold");
    Start = 1'b0;
    reset = 1'b1;
    tick();
    check_idle("rst_rel");

    // Back-to-back single-cycle decodes, one result per cycle
    for (int i = 0; i < 18; i++) begin
      Start = 1'b1;
      ALUOp = vecs[i].op;
      Funct = vecs[i].fn;
      tick();
      check($sformatf("vec%0d_saida", i), 32'(Saida), 32'(vecs[i].sel));
      check($sformatf("vec%0d_ovf", i), 32'(OvfEn), 32'(vecs[i].ovf));
      check($sformatf("vec%0d_done", i), 32'(Done), 32'd1);
      check($sformatf("vec%0d_ready", i), 32'(Ready), 32'd1);
      check($sformatf("vec%0d_busy", i), 32'(Busy), 32'd0);
    end
    Start = 1'b0;
    tick();
    check("b2b_done_drop", 32'(Done), 32'd0);

    // Mul-div sequencing; the MULT run keeps Start high throughout Busy
    run_md("mult", 6'h18, 2'b00, 4, 1'b1);
    run_md("multu", 6'h19, 2'b01, 4, 1'b0);
    run_md("div", 6'h1a, 2'b10, 8, 1'b0);

    // Sticky break
    Start = 1'b1;
    ALUOp = 3'b010;
    Funct = 6'h0d;
    tick();
    check("brk_set", 32'(Break), 32'd1);
    check("brk_saida", 32'(Saida), 32'd0);
    check("brk_done", 32'(Done), 32'd1);
    Start = 1'b0;
    cnt   = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (Break !== 1'b1) cnt++;
    end
    check("brk_hold_10", 32'(cnt), 32'd0);
    Start    = 1'b1;
    BreakClr = 1'b1;
    tick();
    check("brk_set_wins", 32'(Break), 32'd1);
    BreakClr = 1'b0;
    ALUOp    = 3'b000;
    Funct    = 6'h00;
    tick();
    check("brk_noblock_saida", 32'(Saida), 32'd1);
    check("brk_noblock_done", 32'(Done), 32'd1);
    check("brk_noblock_brk", 32'(Break), 32'd1);
    Start    = 1'b0;
    BreakClr = 1'b1;
    tick();
    check("brk_clr", 32'(Break), 32'd0);
    BreakClr = 1'b0;

    // Reset in the middle of a DIVU sequence
    Start = 1'b1;
    ALUOp = 3'b010;
    Funct = 6'h1b;
    tick();
    check("divu_mdop", 32'(MdOp), 32'd3);
    check("divu_busy", 32'(Busy), 32'd1);
    Start = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    check_idle("mid_rst");
    tick();
    tick();
    check_idle("mid_rst_hold");
    reset = 1'b1;
    cnt   = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (Done !== 1'b0) cnt++;
    end
    check("mid_rst_no_done", 32'(cnt), 32'd0);
    check("mid_rst_ready", 32'(Ready), 32'd1);
    Start = 1'b1;
    ALUOp = 3'b000;
    Funct = 6'h00;
    tick();
    check("post_rst_saida", 32'(Saida), 32'd1);
    check("post_rst_done", 32'(Done), 32'd1);
    Start = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
Registered, parametrised ALU control unit for the multicycle MIPS datapath. It decodes ALUOp/Funct into the ALU selector and an overflow-check enable. It sequences multi-cycle MULT/DIV operations with a cycle counter and a Busy/Done handshake. It holds a sticky Break flag until the control FSM clears it. It sits between the main control FSM and the ALU / mul-div datapath.

Parameters:
SEL_W, 3, ALU selector width (Saida)
FUNCT_W, 6, Funct field width
OP_W, 3, ALUOp width
MULT_CYCLES, 32, cycles a MULT/MULTU occupies the mul-div unit (>=2)
DIV_CYCLES, 32, cycles a DIV/DIVU occupies the mul-div unit (>=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
Start  in  1  decode request; sampled only when Ready=1
Funct  in  FUNCT_W  instruction funct field
ALUOp  in  OP_W  operation class from control FSM
BreakClr  in  1  clears sticky Break
Ready  out  1  block accepts Start
Saida  out  SEL_W  registered ALU selector
OvfEn  out  1  registered; overflow trap enabled for this op
MdStart  out  1  one-cycle pulse launching mul-div unit
MdOp  out  2  registered: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
Busy  out  1  mul-div sequence in progress
Done  out  1  one-cycle pulse: decoded result valid / mul-div finished
Break  out  1  sticky BREAK flag

Behaviour:
- Reset (reset=0, async): state IDLE, Saida=0, OvfEn=0, MdStart=0, MdOp=0, Busy=0, Done=0, Break=0, counter=0, Ready=1. All of these hold their values for as long as reset is held.
- Ready = (state==IDLE). Start with Ready=0 is ignored with no side effects.
- Decode table:
  - ALUOp 000 -> 001 (add)
  - ALUOp 001 -> 010 (sub)
  - ALUOp 011 -> 110 (xor)
  - ALUOp 100 -> 011 (and)
  - ALUOp 101 -> 111 (compare, slti)
  - ALUOp 010 uses Funct: 0x20, 0x21 -> 001; 0x22, 0x23 -> 010; 0x24 -> 011; 0x26 -> 110; 0x2a -> 111.
  - Anything else -> 000 (load A).
- OvfEn=1 only for ALUOp 010 with Funct 0x20 or 0x22. All other encodings give OvfEn=0.
- Funct values 0x18/0x19/0x1a/0x1b with ALUOp 010 select a mul-div op; MdOp encodings are 00/01/10/11 respectively.
- FSM states IDLE, MULDIV.
  - IDLE, Start=1, single-cycle op: next edge loads Saida/OvfEn and pulses Done for one cycle. State stays IDLE, so back-to-back Starts give one result per cycle.
  - IDLE, Start=1, mul-div op: next edge loads MdOp, pulses MdStart, and sets Busy=1 and Saida=000. Counter loads N-1 (N = MULT_CYCLES or DIV_CYCLES); state goes to MULDIV.
  - MULDIV: counter decrements each cycle. The edge on which counter==0: Done=1 for one cycle, Busy=0, state returns to IDLE. Total latency from Start to Done is N cycles.
  - Start during MULDIV: ignored.
- Break:
  - Set on an accepted Start with ALUOp 010 and Funct 0x0d; Saida=000 and Done pulses that cycle.
  - BreakClr clears Break. Simultaneous set and clear: set wins.
  - Break does not block further Starts.
- Reset mid-MULDIV: immediate return to IDLE; any pending Done is lost.
- Widths: decode compares use zero-extended constants; the Saida constant is truncated/zero-extended to SEL_W.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - ALUOp encodings
  - Funct constants (ADD, ADDU, SUB, SUBU, AND, XOR, SLT, MULT, MULTU, DIV, DIVU, BREAK)
  - ALU selector constants
  - mul-div op enum
  - state enum
- One natural sub-module, alu_funct_decode: purely combinational, computing Saida/OvfEn/is_muldiv/MdOp/is_break. The top level holds the FSM, counter and registers.

Test Plan:
- Reset low mid-run, then release -> all outputs 0, Ready=1. Start, ALUOp=010, Funct=0x20 -> next cycle Saida=001, OvfEn=1, Done=1 for one cycle.
- Back-to-back Starts on consecutive cycles: ALUOp=011, then 101, then 010/0x21 -> Saida 110, 111, 001 on consecutive cycles. OvfEn is 0, 0, 0; Done stays high 3 cycles.
- MULT_CYCLES=4, Start 010/0x18 -> MdStart pulse, MdOp=00, Busy high 3 cycles, Done on 4th cycle. A Start issued while Busy is ignored and Saida stays 000.
- Funct=0x0d with ALUOp 010 -> Break=1 and held 10 cycles. BreakClr and a new BREAK Start in the same cycle -> Break stays 1. BreakClr alone -> Break=0 next edge.
- DIV_CYCLES=8, Start 010/0x1b, reset asserted at cycle 3 -> Busy=0 immediately, no Done. After release, Start 000 -> Saida=001.
- Unknown Funct 0x3f with ALUOp 010, and ALUOp 111 -> Saida=000, OvfEn=0, Done pulses.
